fadd_norm_fp: RTL and testbench
===============================

Name: fadd_norm_FP

Overview:
- Normalization stage of the FP add/sub datapath.
- Sits between the aligned-mantissa adder and the rounding stage.
- Takes the raw signed-magnitude sum, exponent and special-case flags, and normalizes the sum so the hidden bit lands at sum[47]. It does this with an iterative one-bit-per-cycle left shift, or a single right shift on carry-out.
- Delivers mantissa_norm, exp_norm, grs, underflow and pass-through flags to the rounder over a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width.
- EXT_W, 24, guard/round/sticky extension width. grs[EXT_W-1]=G, grs[EXT_W-2]=R, the rest is OR'd into sticky downstream.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- sum_in  in  49  bit48=carry, [47:24]=integer+fraction, [23:0]=extension.
- exp_in  in  8  larger-operand exponent.
- sign_in  in  1  result sign.
- nan_in, inf1_in, inf2_in, sign1_in, sign2_in  in  1 each  special-case flags.
- out_valid  out  1  result valid.
- out_ready  in  1  rounder accepts.
- mantissa_norm  out  23  normalized sum[46:24].
- exp_norm  out  8  adjusted exponent.
- grs  out  24  normalized sum[23:0].
- underflow  out  1  flush-to-zero request.
- sign_res, NaN, inf1, inf2, sign1, sign2  out  1 each  registered pass-through.

Behaviour:
- Reset is async, active-high. It forces the IDLE state. All outputs are 0 except in_ready=1.
- FSM states: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture all inputs into working registers, go to NORM.
- NORM (in_ready=0, out_valid=0), evaluated in priority order each cycle:
  - nan_in|inf1_in|inf2_in: go to DONE; datapath is don't-care, flags pass through.
  - sum==0: exp=0, mant=0, grs=0, go to DONE.
  - sum[48]=1: shift right 1, exp+1, OR the dropped bit0 into new bit0 (sticky), go to DONE. exp 254 becomes 255; the rounder flags overflow.
  - sum[47]=1: go to DONE unchanged.
  - exp<=1 (includes exp_in=0): underflow=1, exp=0, mant=0, grs=0, go to DONE. Subnormals are not produced.
  - Otherwise: shift left 1 (zero fill), exp-1, stay in NORM.
- DONE:
  - out_valid=1; outputs are stable and held while out_ready=0.
  - On out_ready: go to IDLE. in_ready returns to 1 the next cycle; there is no same-cycle re-accept.
- Latency: input accepted at cycle N gives out_valid at cycle N+2+k, where k is the number of left shifts (0..23).
- Throughput: one beat per (3+k) cycles minimum.
- Exponent arithmetic is 8-bit unsigned. Decrement never goes below 1 because the underflow check precedes the shift.
- The input is sampled only when in_valid && in_ready. in_valid during NORM/DONE is ignored, and the upstream holds the beat.
- Reset mid-operation discards the beat; no out_valid is produced for it.

Optional Feature:
- FADD_NORM_LZC_EN defined:
  - NORM computes the leading-zero count of sum[47:0] combinationally.
  - It applies the full left shift min(lzc, exp-1) in one cycle.
  - If lzc > exp-1, it sets underflow instead.
  - Latency is fixed at N+2, results are bit-identical to the iterative mode, and out_valid timing is independent of k.
- Undefined: iterative one-bit-per-cycle shifting as above, using the smaller single-shifter area.

Test Plan:
- Carry-out: sum[48]=1, [47:24]=24'h800000, [23:0]=24'h000001, exp_in=130 -> exp_norm=131, mantissa_norm=23'h400000, grs=24'h000001 (sticky kept), out_valid at N+2.
- Left shift: [47:24]=24'h100000, ext=0, exp_in=100 -> exp_norm=97, mantissa_norm=0, grs=0. out_valid at N+5 (iterative) or N+2 (LZC_EN).
- Zero sum: sum=0, sign_in=1, exp_in=77 -> exp_norm=0, mantissa_norm=0, grs=0, sign_res=1, underflow=0, out_valid at N+2.
- Underflow: bit40 set only, exp_in=3 -> two shifts then underflow=1, exp_norm=0, mantissa_norm=0, out_valid at N+4.
- Backpressure/special: nan_in=1 with out_ready=0 for 5 cycles -> NaN=1, outputs stable, in_ready=0 throughout. Handshake in cycle 6, then in_ready=1 in cycle 7.
- Reset mid-NORM: assert rst during a 10-shift beat -> in_ready=1, out_valid=0, all outputs 0 immediately. Next beat processes correctly.

Source files
------------

// File: rtl/fadd_norm_fp_if.sv
// Handshake bundle between the aligned-mantissa adder, the normalization stage and the rounder.
interface fadd_norm_fp_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int EXT_W = 24
);
    localparam int SUM_W = MAN_W + EXT_W + 2;

    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] sum_in;
    logic [EXP_W-1:0] exp_in;
    logic             sign_in;
    logic             nan_in;
    logic             inf1_in;
    logic             inf2_in;
    logic             sign1_in;
    logic             sign2_in;

    logic             out_valid;
    logic             out_ready;
    logic [MAN_W-1:0] mantissa_norm;
    logic [EXP_W-1:0] exp_norm;
    logic [EXT_W-1:0] grs;
    logic             underflow;
    logic             sign_res;
    logic             NaN;
    logic             inf1;
    logic             inf2;
    logic             sign1;
    logic             sign2;

    modport master (
        output in_valid, sum_in, exp_in, sign_in, nan_in, inf1_in, inf2_in,
               sign1_in, sign2_in, out_ready,
        input  in_ready, out_valid, mantissa_norm, exp_norm, grs, underflow,
               sign_res, NaN, inf1, inf2, sign1, sign2
    );

    modport slave (
        input  in_valid, sum_in, exp_in, sign_in, nan_in, inf1_in, inf2_in,
               sign1_in, sign2_in, out_ready,
        output in_ready, out_valid, mantissa_norm, exp_norm, grs, underflow,
               sign_res, NaN, inf1, inf2, sign1, sign2
    );
endinterface

// File: rtl/fadd_norm_fp.sv
// FP add/sub normalization stage: moves the hidden bit to sum[MAN_W+EXT_W].
// Define FADD_NORM_LZC_EN for a single-cycle leading-zero-count shift; default shifts one bit per cycle.
module fadd_norm_fp #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int EXT_W = 24
) (
    input logic           clk,
    input logic           rst,
    fadd_norm_fp_if.slave bus
);
    localparam int HID   = MAN_W + EXT_W;
    localparam int SUM_W = HID + 2;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t           state;
    logic [SUM_W-1:0] sum_r;
    logic [EXP_W-1:0] exp_r;
    logic             sign_r, nan_r, inf1_r, inf2_r, sign1_r, sign2_r;
    logic             underflow_r, in_ready_r, out_valid_r;

`ifdef FADD_NORM_LZC_EN
    localparam int LZ_W = $clog2(HID + 2);

    function automatic logic [LZ_W-1:0] lzc_f(input logic [HID:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(HID + 1);
        for (int i = 0; i <= HID; i++)
            if (v[i]) n = LZ_W'(HID - i);
        return n;
    endfunction

    logic [LZ_W-1:0] lzc;
    assign lzc = lzc_f(sum_r[HID:0]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sum_r       <= '0;
            exp_r       <= '0;
            sign_r      <= 1'b0;
            nan_r       <= 1'b0;
            inf1_r      <= 1'b0;
            inf2_r      <= 1'b0;
            sign1_r     <= 1'b0;
            sign2_r     <= 1'b0;
            underflow_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sum_r       <= bus.sum_in;
                        exp_r       <= bus.exp_in;
                        sign_r      <= bus.sign_in;
                        nan_r       <= bus.nan_in;
                        inf1_r      <= bus.inf1_in;
                        inf2_r      <= bus.inf2_in;
                        sign1_r     <= bus.sign1_in;
                        sign2_r     <= bus.sign2_in;
                        underflow_r <= 1'b0;
                        in_ready_r  <= 1'b0;
                        state       <= NORM;
                    end
                end
                NORM: begin
                    if (nan_r | inf1_r | inf2_r) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else if (sum_r == '0) begin
                        exp_r       <= '0;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else if (sum_r[SUM_W-1]) begin
                        // the bit dropped off the bottom must survive as sticky
                        sum_r       <= {1'b0, sum_r[SUM_W-1:2], sum_r[1] | sum_r[0]};
                        exp_r       <= exp_r + 1'b1;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else if (sum_r[HID]) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
`ifdef FADD_NORM_LZC_EN
                    end else if (int'(lzc) >= int'(exp_r)) begin
                        underflow_r <= 1'b1;
                        exp_r       <= '0;
                        sum_r       <= '0;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        sum_r       <= sum_r << lzc;
                        exp_r       <= exp_r - EXP_W'(lzc);
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
`else
                    end else if (exp_r <= EXP_W'(1)) begin
                        underflow_r <= 1'b1;
                        exp_r       <= '0;
                        sum_r       <= '0;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_r - 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.mantissa_norm = sum_r[HID-1:EXT_W];
    assign bus.exp_norm      = exp_r;
    assign bus.grs           = sum_r[EXT_W-1:0];
    assign bus.underflow     = underflow_r;
    assign bus.sign_res      = sign_r;
    assign bus.NaN           = nan_r;
    assign bus.inf1          = inf1_r;
    assign bus.inf2          = inf2_r;
    assign bus.sign1         = sign1_r;
    assign bus.sign2         = sign2_r;
endmodule

// File: tb/tb_fadd_norm_fp.sv
// Scoreboard bench for fadd_norm_fp: directed beats, expected results queued at issue and checked by a monitor.
module tb_fadd_norm_fp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fadd_norm_fp_if bus();
    fadd_norm_fp dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [48:0] sum;
        logic [7:0]  exp;
        logic [5:0]  fl;     // {sign, nan, inf1, inf2, sign1, sign2}
        logic        dc;
        logic [22:0] e_mant;
        logic [7:0]  e_exp;
        logic [23:0] e_grs;
        logic        e_uf;
        int          lat_it;
        int          lat_lz;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    exp_t q[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [48:0] s, input logic [7:0] e, input logic [5:0] fl,
                                input logic [22:0] m, input logic [7:0] ee, input logic [23:0] g,
                                input logic uf, input int li, input int ll);
        vec_t v;
        v.sum = s; v.exp = e; v.fl = fl; v.dc = fl[4] | fl[3] | fl[2];
        v.e_mant = m; v.e_exp = ee; v.e_grs = g; v.e_uf = uf;
        v.lat_it = li; v.lat_lz = ll;
        return v;
    endfunction

    function automatic int lat_of(input vec_t v);
`ifdef FADD_NORM_LZC_EN
        return v.lat_lz;
`else
        return v.lat_it;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: pop on the first cycle of out_valid, then check the held outputs every cycle
    exp_t cur;
    bit   have = 1'b0;
    bit   prev_v = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            have   = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                    have = 1'b0;
                end else begin
                    cur  = q.pop_front();
                    have = 1'b1;
                    chk("latency", 64'(cyc - cur.acc), 64'(lat_of(cur.v)));
                end
            end
            if (bus.out_valid && have) begin
                chk("in_ready_busy", 64'(bus.in_ready), 64'(0));
                chk("flags", 64'({bus.sign_res, bus.NaN, bus.inf1, bus.inf2, bus.sign1, bus.sign2}),
                    64'(cur.v.fl));
                chk("underflow", 64'(bus.underflow), 64'(cur.v.e_uf));
                if (!cur.v.dc) begin
                    chk("mantissa_norm", 64'(bus.mantissa_norm), 64'(cur.v.e_mant));
                    chk("exp_norm", 64'(bus.exp_norm), 64'(cur.v.e_exp));
                    chk("grs", 64'(bus.grs), 64'(cur.v.e_grs));
                end
            end
            if (!bus.out_valid) have = 1'b0;
            prev_v = bus.out_valid;
        end
    end

    task automatic send(input vec_t v, input bit track);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
            return;
        end
        bus.sum_in   = v.sum;
        bus.exp_in   = v.exp;
        {bus.sign_in, bus.nan_in, bus.inf1_in, bus.inf2_in, bus.sign1_in, bus.sign2_in} = v.fl;
        bus.in_valid = 1'b1;
        if (track) begin
            e.v   = v;
            e.acc = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending got %0d expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vec_t vr;
        bus.in_valid = 1'b0;
        bus.sum_in = '0;
        bus.exp_in = '0;
        {bus.sign_in, bus.nan_in, bus.inf1_in, bus.inf2_in, bus.sign1_in, bus.sign2_in} = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_outputs", 64'({bus.mantissa_norm, bus.exp_norm, bus.underflow, bus.sign_res,
                                bus.NaN, bus.inf1, bus.inf2, bus.sign1, bus.sign2}), 64'(0));
        chk("rst_grs", 64'(bus.grs), 64'(0));
        rst = 1'b0;

        vecs.push_back(mk({1'b1, 24'h800000, 24'h000001}, 8'd130, 6'b000000, 23'h400000, 8'd131, 24'h000001, 1'b0, 2, 2));
        vecs.push_back(mk({1'b0, 24'h100000, 24'h000000}, 8'd100, 6'b000000, 23'h000000, 8'd97, 24'h000000, 1'b0, 5, 2));
        vecs.push_back(mk(49'h0, 8'd77, 6'b100000, 23'h0, 8'd0, 24'h0, 1'b0, 2, 2));
        vecs.push_back(mk(49'h10000000000, 8'd3, 6'b000000, 23'h0, 8'd0, 24'h0, 1'b1, 4, 2));
        vecs.push_back(mk({1'b0, 24'hABCDEF, 24'h123456}, 8'd5, 6'b000010, 23'h2BCDEF, 8'd5, 24'h123456, 1'b0, 2, 2));
        vecs.push_back(mk({1'b0, 24'h000001, 24'h800001}, 8'd200, 6'b100001, 23'h400000, 8'd177, 24'h800000, 1'b0, 25, 2));
        vecs.push_back(mk({1'b1, 24'h000000, 24'h000002}, 8'd254, 6'b000000, 23'h0, 8'd255, 24'h000001, 1'b0, 2, 2));
        vecs.push_back(mk({1'b0, 24'h7FFFFF, 24'h000000}, 8'd0, 6'b000000, 23'h0, 8'd0, 24'h0, 1'b1, 2, 2));
        vecs.push_back(mk(49'h200000000000, 8'd3, 6'b000000, 23'h0, 8'd1, 24'h0, 1'b0, 4, 2));
        vecs.push_back(mk({1'b0, 24'h000010, 24'h000000}, 8'd50, 6'b001000, 23'h0, 8'd0, 24'h0, 1'b0, 2, 2));
        vecs.push_back(mk({1'b1, 24'h000001, 24'h000000}, 8'd10, 6'b000101, 23'h0, 8'd0, 24'h0, 1'b0, 2, 2));

        foreach (vecs[i]) send(vecs[i], 1'b1);
        drain();

        // backpressure on a NaN beat
        bus.out_ready = 1'b0;
        send(mk(49'h123, 8'd9, 6'b010000, 23'h0, 8'd0, 24'h0, 1'b0, 2, 2), 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
        repeat (5) @(negedge clk);
        chk("bp_held_valid", 64'(bus.out_valid), 64'(1));
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_after", 64'(bus.in_ready), 64'(1));
        chk("bp_out_valid_after", 64'(bus.out_valid), 64'(0));
        drain();

        // reset in the middle of a ten-shift beat
        vr = mk(49'h2000000000, 8'd100, 6'b100010, 23'h0, 8'd90, 24'h0, 1'b0, 12, 2);
        send(vr, 1'b0);
`ifndef FADD_NORM_LZC_EN
        repeat (3) @(negedge clk);
`endif
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_outputs", 64'({bus.mantissa_norm, bus.exp_norm, bus.underflow, bus.sign_res,
                                   bus.NaN, bus.inf1, bus.inf2, bus.sign1, bus.sign2}), 64'(0));
        chk("midrst_grs", 64'(bus.grs), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        send(vr, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
